// File: rtl/loop_replay_buffer.sv
// Loop replay buffer: spots a short backward loop, captures its body once it
// is confident, and then replays the body to decode while fetch is held off.
module loop_replay_buffer #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 32,
    parameter int CONF_THRESH = 2,
    parameter int ITER_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic [XLEN-1:0]   fetch_pc,
    input  logic [31:0]       fetch_instr,
    input  logic [XLEN-1:0]   branch_imm,
    input  logic              mispredict,
    input  logic              replay_stall,
    output logic              replay_valid,
    output logic [31:0]       replay_instr,
    output logic [XLEN-1:0]   replay_pc,
    output logic              block_fetch,
    output logic              flush,
    output logic [XLEN-1:0]   resume_pc,
    output logic [ITER_W-1:0] iter_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CONF_THRESH + 1) + 1;

    typedef enum logic [1:0] {IDLE, ARM, FILL, REPLAY} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   br_pc_q, br_pc_d;
    logic [XLEN-1:0]   start_pc_q, start_pc_d;
    logic [AW-1:0]     last_q, last_d;
    logic [CW-1:0]     conf_q, conf_d;
    logic              capturing_q, capturing_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [XLEN-1:0]   resume_q, resume_d;
    logic [31:0]       body_mem [DEPTH];

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [6:0]        opc;
    logic              is_br_op, is_cf, candidate, in_range;
    logic [XLEN-1:0]   neg_imm, body_len, fill_off;

    assign opc      = fetch_instr[6:0];
    assign is_br_op = (opc == 7'b1100011) || (opc == 7'b1101111);
    assign is_cf    = is_br_op || (opc == 7'b1100111);
    assign neg_imm  = -branch_imm;
    assign body_len = (neg_imm >> 2) + XLEN'(1);
    assign candidate = fetch_valid && is_br_op && branch_imm[XLEN-1]
                       && (branch_imm[1:0] == 2'b00) && (body_len <= XLEN'(DEPTH));
    assign fill_off = fetch_pc - start_pc_q;
    assign in_range = (fetch_pc >= start_pc_q) && (fetch_pc <= br_pc_q);

    always_comb begin
        state_d     = state_q;
        br_pc_d     = br_pc_q;
        start_pc_d  = start_pc_q;
        last_d      = last_q;
        conf_d      = conf_q;
        capturing_d = capturing_q;
        rd_ptr_d    = rd_ptr_q;
        iter_d      = iter_q;
        resume_d    = resume_q;
        mem_we      = 1'b0;
        mem_waddr   = AW'(fill_off >> 2);

        case (state_q)
            IDLE: begin
                if (!mispredict && candidate) begin
                    br_pc_d    = fetch_pc;
                    start_pc_d = fetch_pc + branch_imm;
                    last_d     = AW'(neg_imm >> 2);
                    conf_d     = CW'(1);
                    if (CONF_THRESH == 1) begin
                        state_d     = FILL;
                        capturing_d = 1'b0;
                        iter_d      = '0;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                if (mispredict) begin
                    state_d = IDLE;
                end else if (candidate) begin
                    if (fetch_pc == br_pc_q) begin
                        conf_d = conf_q + CW'(1);
                        if (int'(conf_q) + 1 >= CONF_THRESH) begin
                            state_d     = FILL;
                            capturing_d = 1'b0;
                            iter_d      = '0;
                        end
                    end else begin
                        br_pc_d    = fetch_pc;
                        start_pc_d = fetch_pc + branch_imm;
                        last_d     = AW'(neg_imm >> 2);
                        conf_d     = CW'(1);
                    end
                end
            end
            FILL: begin
                // Fetches before the loop head are ignored; capture latches on at start_pc.
                if (mispredict) begin
                    state_d = IDLE;
                end else if (fetch_valid && (capturing_q || fetch_pc == start_pc_q)) begin
                    capturing_d = 1'b1;
                    if (!in_range) begin
                        state_d = IDLE;
                    end else if (is_cf && fetch_pc != br_pc_q) begin
                        state_d = IDLE;
                    end else begin
                        mem_we = 1'b1;
                        if (fetch_pc == br_pc_q) begin
                            state_d  = REPLAY;
                            rd_ptr_d = '0;
                            resume_d = br_pc_q + XLEN'(4);
                        end
                    end
                end
            end
            REPLAY: begin
                if (mispredict) begin
                    state_d = IDLE;
                end else if (!replay_stall) begin
                    if (rd_ptr_q == last_q) begin
                        rd_ptr_d = '0;
                        if (iter_q != '1) iter_d = iter_q + ITER_W'(1);
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            br_pc_q     <= '0;
            start_pc_q  <= '0;
            last_q      <= '0;
            conf_q      <= '0;
            capturing_q <= 1'b0;
            rd_ptr_q    <= '0;
            iter_q      <= '0;
            resume_q    <= '0;
        end else begin
            state_q     <= state_d;
            br_pc_q     <= br_pc_d;
            start_pc_q  <= start_pc_d;
            last_q      <= last_d;
            conf_q      <= conf_d;
            capturing_q <= capturing_d;
            rd_ptr_q    <= rd_ptr_d;
            iter_q      <= iter_d;
            resume_q    <= resume_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) body_mem[mem_waddr] <= fetch_instr;
    end

    // flush/replay_valid depend on mispredict combinationally so the exit takes effect this cycle.
    assign block_fetch  = (state_q == REPLAY);
    assign replay_valid = (state_q == REPLAY) && !mispredict;
    assign flush        = (state_q == REPLAY) && mispredict;
    assign replay_instr = (state_q == REPLAY) ? body_mem[rd_ptr_q] : '0;
    assign replay_pc    = (state_q == REPLAY) ? start_pc_q + (XLEN'(rd_ptr_q) << 2) : '0;
    assign resume_pc    = resume_q;
    assign iter_count   = iter_q;

endmodule

// File: tb/tb_loop_replay_buffer.sv
// Directed bench for loop_replay_buffer: a vector table for the basic
// detect/capture/replay/exit flow plus hand sequences for the corner cases.
module tb_loop_replay_buffer;

    localparam int XLEN = 32;
    localparam int ITW  = 2;

    logic            clk = 1'b0;
    logic            reset, fetch_valid, mispredict, replay_stall;
    logic [XLEN-1:0] fetch_pc, branch_imm;
    logic [31:0]     fetch_instr;
    logic            replay_valid, block_fetch, flush;
    logic [31:0]     replay_instr;
    logic [XLEN-1:0] replay_pc, resume_pc;
    logic [ITW-1:0]  iter_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    loop_replay_buffer #(.XLEN(XLEN), .DEPTH(32), .CONF_THRESH(2), .ITER_W(ITW)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .branch_imm(branch_imm), .mispredict(mispredict),
        .replay_stall(replay_stall), .replay_valid(replay_valid), .replay_instr(replay_instr),
        .replay_pc(replay_pc), .block_fetch(block_fetch), .flush(flush),
        .resume_pc(resume_pc), .iter_count(iter_count)
    );

    typedef struct {
        logic        rst, fv, mp, st;
        logic [31:0] pc, instr, imm;
        logic        rv, bf, fl;
        logic [31:0] rpc, rinstr, resume, iter;
    } vec_t;

    vec_t tab[$];

    function automatic logic [31:0] ins(input logic [31:0] pc, input logic br);
        return {pc[24:0], br ? 7'h63 : 7'h13};
    endfunction

    function automatic vec_t mk(input logic rst, fv, mp, st, input logic [31:0] pc, instr, imm,
                                input logic rv, bf, fl, input logic [31:0] rpc, resume, iter,
                                input logic rbr);
        vec_t v;
        v.rst = rst; v.fv = fv; v.mp = mp; v.st = st;
        v.pc = pc; v.instr = instr; v.imm = imm;
        v.rv = rv; v.bf = bf; v.fl = fl;
        v.rpc = rpc; v.rinstr = ins(rpc, rbr); v.resume = resume; v.iter = iter;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, fv, input logic [31:0] pc, instr, imm, input logic mp, st);
        @(negedge clk);
        reset = rst; fetch_valid = fv; fetch_pc = pc; fetch_instr = instr;
        branch_imm = imm; mispredict = mp; replay_stall = st;
        #1;
    endtask

    task automatic idle_step(input logic mp, st);
        drive(1'b0, 1'b0, '0, '0, '0, mp, st);
    endtask

    task automatic expect_replay(input string tag, input logic [31:0] pc, input logic br,
                                 input logic [31:0] resume, input logic [31:0] iter);
        check({tag, ".rv"}, 32'(replay_valid), 32'd1);
        check({tag, ".bf"}, 32'(block_fetch), 32'd1);
        check({tag, ".fl"}, 32'(flush), 32'd0);
        check({tag, ".rpc"}, replay_pc, pc);
        check({tag, ".rinstr"}, replay_instr, ins(pc, br));
        check({tag, ".resume"}, resume_pc, resume);
        check({tag, ".iter"}, 32'(iter_count), iter);
    endtask

    task automatic expect_exit(input string tag, input logic [31:0] resume, input logic [31:0] iter);
        check({tag, ".rv"}, 32'(replay_valid), 32'd0);
        check({tag, ".bf"}, 32'(block_fetch), 32'd1);
        check({tag, ".fl"}, 32'(flush), 32'd1);
        check({tag, ".resume"}, resume_pc, resume);
        check({tag, ".iter"}, 32'(iter_count), iter);
        idle_step(1'b0, 1'b0);
        check({tag, ".idle_rv"}, 32'(replay_valid), 32'd0);
        check({tag, ".idle_bf"}, 32'(block_fetch), 32'd0);
        check({tag, ".idle_fl"}, 32'(flush), 32'd0);
        check({tag, ".idle_resume"}, resume_pc, resume);
        check({tag, ".idle_iter"}, 32'(iter_count), iter);
    endtask

    // One sequential pass of an n-instruction loop ending in a backward branch.
    task automatic do_pass(input string tag, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] pc;
            logic        br;
            pc = base + 32'(4 * i);
            br = (i == n - 1);
            drive(1'b0, 1'b1, pc, ins(pc, br), br ? -32'(4 * (n - 1)) : 32'd0, 1'b0, 1'b0);
            check({tag, ".pass_rv"}, 32'(replay_valid), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
        branch_imm = '0; mispredict = 1'b0; replay_stall = 1'b0;

        // Reset row, then three passes of the 0x100..0x10C loop, replay, exit.
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++)
                tab.push_back(mk(0, 1, 0, 0, 32'h100 + 32'(4 * i), ins(32'h100 + 32'(4 * i), i == 3),
                                 (i == 3) ? 32'hFFFF_FFF4 : 32'd0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100 + 32'(4 * (k % 4)),
                             32'h110, (k >= 4) ? 32'd1 : 32'd0, (k % 4) == 3));
        tab.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h110, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h110, 1, 0));

        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        foreach (tab[n]) begin
            drive(tab[n].rst, tab[n].fv, tab[n].pc, tab[n].instr, tab[n].imm, tab[n].mp, tab[n].st);
            if (n == 1) begin
                check("reset.rpc", replay_pc, 32'd0);
                check("reset.rinstr", replay_instr, 32'd0);
            end
            if (n >= 1) begin
                check($sformatf("tab%0d.rv", n), 32'(replay_valid), 32'(tab[n].rv));
                check($sformatf("tab%0d.bf", n), 32'(block_fetch), 32'(tab[n].bf));
                check($sformatf("tab%0d.fl", n), 32'(flush), 32'(tab[n].fl));
                check($sformatf("tab%0d.resume", n), resume_pc, tab[n].resume);
                check($sformatf("tab%0d.iter", n), 32'(iter_count), tab[n].iter);
                if (tab[n].rv) begin
                    check($sformatf("tab%0d.rpc", n), replay_pc, tab[n].rpc);
                    check($sformatf("tab%0d.rinstr", n), replay_instr, tab[n].rinstr);
                end
            end
        end

        // Stall mid-replay, then mispredict together with stall.
        for (int p = 0; p < 3; p++) do_pass("stall", 32'h100, 4);
        idle_step(1'b0, 1'b0); expect_replay("stall.r0", 32'h100, 0, 32'h110, 0);
        idle_step(1'b0, 1'b0); expect_replay("stall.r1", 32'h104, 0, 32'h110, 0);
        for (int i = 0; i < 3; i++) begin
            idle_step(1'b0, 1'b1); expect_replay("stall.hold", 32'h108, 0, 32'h110, 0);
        end
        idle_step(1'b0, 1'b0); expect_replay("stall.rel", 32'h108, 0, 32'h110, 0);
        idle_step(1'b0, 1'b0); expect_replay("stall.r3", 32'h10C, 1, 32'h110, 0);
        idle_step(1'b0, 1'b0); expect_replay("stall.wrap", 32'h100, 0, 32'h110, 1);
        idle_step(1'b1, 1'b1); expect_exit("stall.exit", 32'h110, 1);

        // Inner branch during capture aborts it.
        for (int p = 0; p < 2; p++) do_pass("abort", 32'h100, 4);
        drive(1'b0, 1'b1, 32'h100, ins(32'h100, 0), 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h104, ins(32'h104, 1), 32'h10, 1'b0, 1'b0);
        do_pass("abort.after", 32'h100, 4);
        for (int i = 0; i < 3; i++) begin
            idle_step(1'b0, 1'b0);
            check("abort.rv", 32'(replay_valid), 32'd0);
            check("abort.bf", 32'(block_fetch), 32'd0);
        end

        // 33-instruction body is too long; 32 is captured and wraps 31 -> 0.
        for (int p = 0; p < 3; p++) do_pass("len33", 32'h200, 33);
        for (int i = 0; i < 3; i++) begin
            idle_step(1'b0, 1'b0);
            check("len33.rv", 32'(replay_valid), 32'd0);
        end
        for (int p = 0; p < 3; p++) do_pass("len32", 32'h300, 32);
        for (int k = 0; k < 33; k++) begin
            idle_step(1'b0, 1'b0);
            expect_replay($sformatf("len32.r%0d", k), 32'h300 + 32'(4 * (k % 32)), (k % 32) == 31,
                          32'h380, (k >= 32) ? 32'd1 : 32'd0);
        end
        idle_step(1'b1, 1'b0); expect_exit("len32.exit", 32'h380, 1);

        // Iteration counter saturates at 3, then reset mid-replay.
        for (int p = 0; p < 3; p++) do_pass("sat", 32'h100, 4);
        for (int k = 0; k < 21; k++) begin
            idle_step(1'b0, 1'b0);
            expect_replay($sformatf("sat.r%0d", k), 32'h100 + 32'(4 * (k % 4)), (k % 4) == 3,
                          32'h110, (k / 4 > 3) ? 32'd3 : 32'(k / 4));
        end
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        idle_step(1'b0, 1'b0);
        check("rst.rv", 32'(replay_valid), 32'd0);
        check("rst.bf", 32'(block_fetch), 32'd0);
        check("rst.fl", 32'(flush), 32'd0);
        check("rst.rpc", replay_pc, 32'd0);
        check("rst.rinstr", replay_instr, 32'd0);
        check("rst.resume", resume_pc, 32'd0);
        check("rst.iter", 32'(iter_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
